// File: rtl/trace_dump_ctrl_if.sv
// rtl/trace_dump_ctrl_if.sv - trace buffer read port plus outgoing byte stream
// Signals:
//   trace_wr  : copy of the trace buffer write strobe (observed only)
//   trace_rd  : buffer read pulse, one cycle per word
//   trace_out : buffer read data, valid the cycle after trace_rd
//   tx_data/tx_valid/tx_ready : framed byte stream toward the debug bridge
// Modports: master = readout controller, slave = buffer + stream sink side.
interface trace_dump_ctrl_if #(
  parameter int Fpay = 32
) ();
  logic            trace_wr;
  logic            trace_rd;
  logic [Fpay-1:0] trace_out;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;

  modport master (
    input  trace_wr,
    input  trace_out,
    input  tx_ready,
    output trace_rd,
    output tx_data,
    output tx_valid
  );

  modport slave (
    output trace_wr,
    output trace_out,
    output tx_ready,
    input  trace_rd,
    input  tx_data,
    input  tx_valid
  );
endinterface

// File: rtl/trace_dump_ctrl.sv
// rtl/trace_dump_ctrl.sv - drains the trace buffer into a framed byte stream
// Frame: header(A5/A6), COUNT[15:8], COUNT[7:0], COUNT words MSB byte first,
//        [XOR checksum], trailer 5A.
// Optional feature macro: TRACE_DUMP_CHKSUM_EN (adds the CHK checksum byte).
// Ports:
//   clk        : system clock (same as trace buffer)
//   reset      : asynchronous active-low reset
//   bus        : trace_dump_ctrl_if.master (buffer read port + byte stream)
//   dump_start : single-cycle dump request, ignored while busy
//   busy       : high whenever the FSM is not IDLE
//   overflow   : sticky, buffer written while full; cleared at dump start
module trace_dump_ctrl #(
  parameter int Fpay     = 32,
  parameter int TB_Depth = 512,
  parameter int CNTw     = $clog2(TB_Depth) + 1
) (
  input  logic              clk,
  input  logic              reset,
  trace_dump_ctrl_if.master bus,
  input  logic              dump_start,
  output logic              busy,
  output logic              overflow
);
  localparam int NB  = Fpay / 8;
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNTw-1:0] FULL    = CNTw'(TB_Depth);
  localparam logic [7:0]      HDR_OK  = 8'hA5;
  localparam logic [7:0]      HDR_OVF = 8'hA6;
  localparam logic [7:0]      TRAILER = 8'h5A;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    CNT_H,
    CNT_L,
    RD,
    CAP,
    DATA,
`ifdef TRACE_DUMP_CHKSUM_EN
    CHK,
`endif
    TRL
  } state_t;

  state_t          state;
  logic [CNTw-1:0] occ;
  logic [15:0]     count;
  logic [CNTw-1:0] remaining;
  logic [Fpay-1:0] shreg;
  logic [BIW-1:0]  byte_idx;
`ifdef TRACE_DUMP_CHKSUM_EN
  logic [7:0]      chk;
`endif

  logic            hs;
  logic            start;
  logic            wr_ok;
  logic            wr_full;
  logic [Fpay-1:0] shreg_sh;

  assign hs       = bus.tx_valid & bus.tx_ready;
  assign start    = dump_start & (state == IDLE);
  assign wr_full  = bus.trace_wr & (occ == FULL);
  assign wr_ok    = bus.trace_wr & (occ != FULL);
  assign shreg_sh = shreg << 8;

  // Occupancy shadow of the buffer. A write while full is lost (and flagged),
  // even if a read happens in the same cycle. A fresh overflow in the start
  // cycle wins over the clear since it was not part of the snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (start)   overflow <= 1'b0;
      if (wr_full) overflow <= 1'b1;
      case ({wr_ok, bus.trace_rd})
        2'b10:   occ <= occ + CNTw'(1);
        2'b01:   occ <= occ - CNTw'(1);
        default: ;
      endcase
    end
  end

  // Outputs are registered: each transition loads the byte the next state shows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bus.trace_rd <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= 8'h00;
      busy         <= 1'b0;
      count        <= '0;
      remaining    <= '0;
      shreg        <= '0;
      byte_idx     <= '0;
`ifdef TRACE_DUMP_CHKSUM_EN
      chk          <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (dump_start) begin
            count        <= 16'(occ);
            remaining    <= occ;
            bus.tx_data  <= overflow ? HDR_OVF : HDR_OK;
            bus.tx_valid <= 1'b1;
            busy         <= 1'b1;
`ifdef TRACE_DUMP_CHKSUM_EN
            chk          <= 8'h00;
`endif
            state        <= HDR;
          end
        end
        HDR: begin
          if (hs) begin
            bus.tx_data <= count[15:8];
            state       <= CNT_H;
          end
        end
        CNT_H: begin
          if (hs) begin
`ifdef TRACE_DUMP_CHKSUM_EN
            chk         <= chk ^ bus.tx_data;
`endif
            bus.tx_data <= count[7:0];
            state       <= CNT_L;
          end
        end
        CNT_L: begin
          if (hs) begin
`ifdef TRACE_DUMP_CHKSUM_EN
            chk <= chk ^ bus.tx_data;
`endif
            if (count != 16'h0000) begin
              bus.tx_valid <= 1'b0;
              bus.trace_rd <= 1'b1;
              state        <= RD;
            end else begin
`ifdef TRACE_DUMP_CHKSUM_EN
              bus.tx_data <= chk ^ bus.tx_data;
              state       <= CHK;
`else
              bus.tx_data <= TRAILER;
              state       <= TRL;
`endif
            end
          end
        end
        RD: begin
          bus.trace_rd <= 1'b0;
          state        <= CAP;
        end
        CAP: begin
          shreg        <= bus.trace_out;
          byte_idx     <= '0;
          bus.tx_data  <= bus.trace_out[Fpay-1 -: 8];
          bus.tx_valid <= 1'b1;
          state        <= DATA;
        end
        DATA: begin
          if (hs) begin
`ifdef TRACE_DUMP_CHKSUM_EN
            chk <= chk ^ bus.tx_data;
`endif
            if (byte_idx == BIW'(NB - 1)) begin
              remaining <= remaining - CNTw'(1);
              if (remaining > CNTw'(1)) begin
                bus.tx_valid <= 1'b0;
                bus.trace_rd <= 1'b1;
                state        <= RD;
              end else begin
`ifdef TRACE_DUMP_CHKSUM_EN
                bus.tx_data <= chk ^ bus.tx_data;
                state       <= CHK;
`else
                bus.tx_data <= TRAILER;
                state       <= TRL;
`endif
              end
            end else begin
              shreg       <= shreg_sh;
              byte_idx    <= byte_idx + BIW'(1);
              bus.tx_data <= shreg_sh[Fpay-1 -: 8];
            end
          end
        end
`ifdef TRACE_DUMP_CHKSUM_EN
        CHK: begin
          if (hs) begin
            bus.tx_data <= TRAILER;
            state       <= TRL;
          end
        end
`endif
        TRL: begin
          if (hs) begin
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= 8'h00;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trace_dump_ctrl.sv
// tb/tb_trace_dump_ctrl.sv - self-checking bench for trace_dump_ctrl
module tb_trace_dump_ctrl;
  localparam int FPAY  = 32;
  localparam int DEPTH = 512;
  localparam int NB    = FPAY / 8;
`ifdef TRACE_DUMP_CHKSUM_EN
  localparam int CHK_EXTRA = 1;
`else
  localparam int CHK_EXTRA = 0;
`endif

  logic clk;
  logic reset;
  logic dump_start;
  logic busy;
  logic overflow;

  trace_dump_ctrl_if #(.Fpay(FPAY)) bus ();

  trace_dump_ctrl #(.Fpay(FPAY), .TB_Depth(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dump_start (dump_start),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;

  logic [31:0] buf_q[$];
  logic [7:0]  rx_q[$];
  logic [31:0] wr_data;
  bit          ref_ovf;
  int          rd_pulses;
  bit          prev_stall;
  logic [7:0]  prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Buffer emulation, stream collector and stall-stability monitor
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall    = 1'b0;
      bus.trace_out = '0;
    end else begin
      bit full;
      if (prev_stall) begin
        asserts++;
        if (!(bus.tx_valid === 1'b1 && bus.tx_data === prev_data)) begin
          fails++;
          $display("FAIL stall_hold: got valid=%0b data=0x%0h expected valid=1 data=0x%0h",
                   bus.tx_valid, bus.tx_data, prev_data);
        end
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) rx_q.push_back(bus.tx_data);
      full = (buf_q.size() >= DEPTH);
      if (bus.trace_rd) begin
        rd_pulses++;
        if (buf_q.size() > 0) bus.trace_out = buf_q.pop_front();
        else begin
          asserts++; fails++;
          $display("FAIL rd_empty: got trace_rd=1 expected no read of empty buffer");
        end
      end
      if (bus.trace_wr) begin
        if (full) ref_ovf = 1'b1;
        else buf_q.push_back(wr_data);
      end
    end
  end

  task automatic write_word(input logic [31:0] w);
    @(posedge clk); #1;
    bus.trace_wr = 1'b1;
    wr_data      = w;
  endtask

  task automatic wr_done();
    @(posedge clk); #1;
    bus.trace_wr = 1'b0;
  endtask

  task automatic do_dump(input bit rnd, input bit inject, input logic [7:0] exp_hdr,
                         input int exp_cnt, input string tag);
    logic [7:0] exp[$];
    logic [7:0] x;
    logic [7:0] by;
    int n;
    int cyc;
    bit injected;
    n = buf_q.size();
    exp.push_back(ref_ovf ? 8'hA6 : 8'hA5);
    exp.push_back(8'(n >> 8));
    exp.push_back(8'(n));
    x = 8'(n >> 8) ^ 8'(n);
    for (int i = 0; i < n; i++) begin
      for (int b = NB - 1; b >= 0; b--) begin
        by = 8'(buf_q[i] >> (8 * b));
        exp.push_back(by);
        x = x ^ by;
      end
    end
    if (CHK_EXTRA == 1) exp.push_back(x);
    exp.push_back(8'h5A);
    rx_q.delete();
    rd_pulses = 0;
    injected  = 1'b0;
    @(posedge clk); #1;
    dump_start   = 1'b1;
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
    ref_ovf    = 1'b0;
    check({tag, "_valid_rise"}, 32'(bus.tx_valid), 32'd1);
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    check({tag, "_ovf_clr"}, 32'(overflow), 32'd0);
    cyc = 0;
    while (busy && cyc < 20000) begin
      bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject && !injected && bus.trace_rd) begin
        bus.trace_wr = 1'b1;
        wr_data      = $urandom;
        injected     = 1'b1;
      end else begin
        bus.trace_wr = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.trace_wr = 1'b0;
    bus.tx_ready = 1'b0;
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_nbytes"}, rx_q.size(), exp.size());
    if (rx_q.size() >= 3) begin
      check({tag, "_hdr"}, 32'(rx_q[0]), 32'(exp_hdr));
      check({tag, "_count"}, {16'h0, rx_q[1], rx_q[2]}, 32'(exp_cnt));
    end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp[i]));
    check({tag, "_rd_pulses"}, rd_pulses, exp_cnt);
    if (inject) check({tag, "_inject_hit"}, 32'(injected), 32'd1);
    if (!rnd && !inject)
      check({tag, "_frame_len"}, cyc, 3 + exp_cnt * (NB + 2) + 1 + CHK_EXTRA);
    check({tag, "_occ_after"}, 32'(dut.occ), buf_q.size());
  endtask

  typedef struct {
    int         nwr;
    bit         rnd;
    logic [7:0] hdr;
    int         cnt;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] two_exp[$];
  int         nr;

  initial begin
    vecs[0] = '{0,   1'b0, 8'hA5, 0};
    vecs[1] = '{1,   1'b0, 8'hA5, 1};
    vecs[2] = '{3,   1'b1, 8'hA5, 3};
    vecs[3] = '{6,   1'b1, 8'hA5, 6};
    vecs[4] = '{513, 1'b0, 8'hA6, 512};

    two_exp = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                8'hDE, 8'hAD, 8'hBE, 8'hEF};
    if (CHK_EXTRA == 1) two_exp.push_back(8'h64);
    two_exp.push_back(8'h5A);

    reset        = 1'b0;
    dump_start   = 1'b0;
    bus.trace_wr = 1'b0;
    bus.tx_ready = 1'b0;
    wr_data      = '0;
    ref_ovf      = 1'b0;
    rd_pulses    = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_trace_rd", 32'(bus.trace_rd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_occ", 32'(dut.occ), 32'd0);
    reset = 1'b1;

    // Table-driven dumps
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].nwr; i++) write_word($urandom);
      if (vecs[v].nwr > 0) wr_done();
      if (vecs[v].nwr > DEPTH) check($sformatf("vec%0d_ovf_set", v), 32'(overflow), 32'd1);
      do_dump(vecs[v].rnd, 1'b0, vecs[v].hdr, vecs[v].cnt, $sformatf("vec%0d", v));
    end

    // Fixed two-word frame, then the same words under random backpressure
    for (int pass = 0; pass < 2; pass++) begin
      write_word(32'h11223344);
      write_word(32'hDEADBEEF);
      wr_done();
      do_dump(pass == 1, 1'b0, 8'hA5, 2, pass == 0 ? "two" : "two_bp");
      check($sformatf("two%0d_len", pass), rx_q.size(), two_exp.size());
      for (int i = 0; i < two_exp.size() && i < rx_q.size(); i++)
        check($sformatf("two%0d_const%0d", pass, i), 32'(rx_q[i]), 32'(two_exp[i]));
    end

    // Random rounds against the model
    for (int r = 0; r < 4; r++) begin
      nr = $urandom_range(0, 8);
      for (int i = 0; i < nr; i++) write_word($urandom);
      if (nr > 0) wr_done();
      do_dump(1'b1, 1'b0, 8'hA5, nr, $sformatf("rnd%0d", r));
    end

    // Write lands in the same cycle as a read
    for (int i = 0; i < 3; i++) write_word($urandom);
    wr_done();
    do_dump(1'b0, 1'b1, 8'hA5, 3, "conc");
    check("conc_occ_one", 32'(dut.occ), 32'd1);
    do_dump(1'b0, 1'b0, 8'hA5, 1, "conc2");

    // Asynchronous reset in the middle of DATA
    write_word(32'hCAFEF00D);
    write_word(32'h01234567);
    wr_done();
    rx_q.delete();
    rd_pulses = 0;
    @(posedge clk); #1;
    dump_start   = 1'b1;
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
    nr = 0;
    while (!(rd_pulses >= 1 && bus.tx_valid) && nr < 50) begin
      @(posedge clk); #1;
      nr++;
    end
    check("arst_reached_data", 32'(nr < 50), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_occ", 32'(dut.occ), 32'd0);
    check("arst_trace_rd", 32'(bus.trace_rd), 32'd0);
    buf_q.delete();
    ref_ovf      = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    do_dump(1'b0, 1'b0, 8'hA5, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
